// File: rtl/hilo_pkg.sv
// Shared types and defaults for the HI/LO sequencer: state encoding, cycle counts, counter width.
package hilo_pkg;

  localparam int HILO_CNT_W      = 6;
  localparam int HILO_RUN_CYCLES = 33;
  localparam int HILO_TIMEOUT    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } hilo_state_e;

endpackage

// File: rtl/hilo_sequencer_if.sv
// Link between the HI/LO sequencer (master) and the Booth multiplier (slave).
interface hilo_sequencer_if;

  // Handshake: the master presents MultA/MultB and holds MultControl high for the
  // whole run; the slave answers with MultOut=1 and a valid MultHi/MultLo, holding
  // both until the master pulses MultClr for one cycle to return it to idle.
  logic [31:0] MultA;
  logic [31:0] MultB;
  logic        MultControl;
  logic        MultClr;
  logic [31:0] MultHi;
  logic [31:0] MultLo;
  logic        MultOut;

  modport master (
    output MultA, MultB, MultControl, MultClr,
    input  MultHi, MultLo, MultOut
  );

  modport slave (
    input  MultA, MultB, MultControl, MultClr,
    output MultHi, MultLo, MultOut
  );

endinterface

// File: rtl/hilo_sequencer.sv
// Multiply sequencer and architectural HI/LO holder in front of the Booth multiplier.
// Optional DRAIN timeout is built only when HILO_TIMEOUT_EN is defined.
module hilo_sequencer
  import hilo_pkg::*;
#(
  parameter int RUN_CYCLES = HILO_RUN_CYCLES,
  parameter int TIMEOUT    = HILO_TIMEOUT
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [31:0]             OpA,
  input  logic [31:0]             OpB,
  input  logic                    MtHi,
  input  logic                    MtLo,
  input  logic [31:0]             WrData,
  hilo_sequencer_if.master        mult,
  output logic [31:0]             Hi,
  output logic [31:0]             Lo,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error,
  output hilo_state_e             State
);

  localparam logic [HILO_CNT_W-1:0] RUN_LOAD = HILO_CNT_W'(RUN_CYCLES);
  localparam logic [HILO_CNT_W-1:0] TO_LOAD  = HILO_CNT_W'(TIMEOUT);
  localparam logic [HILO_CNT_W-1:0] CNT_ONE  = HILO_CNT_W'(1);

  hilo_state_e           state;
  logic [HILO_CNT_W-1:0] cnt;
  logic [31:0]           hi_q;
  logic [31:0]           lo_q;
  logic [31:0]           mult_a;
  logic [31:0]           mult_b;
  logic                  mult_control;
  logic                  done_q;

  // One counter serves both phases: run length in RUN, timeout budget in DRAIN.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mult_a       <= '0;
      mult_b       <= '0;
      mult_control <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (MtHi) hi_q <= WrData;
          if (MtLo) lo_q <= WrData;
          if (Start) begin
            mult_a       <= OpA;
            mult_b       <= OpB;
            cnt          <= RUN_LOAD;
            mult_control <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (cnt == CNT_ONE) begin
            mult_control <= 1'b0;
            cnt          <= TO_LOAD;
            state        <= DRAIN;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DRAIN: begin
          if (mult.MultOut) begin
            hi_q   <= mult.MultHi;
            lo_q   <= mult.MultLo;
            done_q <= 1'b1;
            state  <= CLEAR;
          end
`ifdef HILO_TIMEOUT_EN
          else if (cnt == CNT_ONE) begin
            state <= CLEAR;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
`endif
        end
        CLEAR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HILO_TIMEOUT_EN
  logic error_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= (state == DRAIN) && !mult.MultOut && (cnt == CNT_ONE);
    end
  end

  assign Error = error_q;
`else
  assign Error = 1'b0;
`endif

  assign mult.MultA       = mult_a;
  assign mult.MultB       = mult_b;
  assign mult.MultControl = mult_control;
  assign mult.MultClr     = (state == CLEAR);

  assign Hi    = hi_q;
  assign Lo    = lo_q;
  assign Busy  = (state != IDLE);
  assign Done  = done_q;
  assign State = state;

endmodule

// File: doc/hilo_sequencer.md
# hilo_sequencer

Sequencer and architectural HI/LO register holder between the control unit and the Booth multiplier. It accepts a multiply request and launches the multiplier. It holds the multiplier's enable for the full iteration count, then waits for the completion flag and captures the 64-bit product into HI/LO. It then clears the multiplier for the next operation and stalls the control unit for the whole sequence. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

## Interface
- RUN_CYCLES, 33, cycles MultControl is held high (1 load cycle + 32 Booth iterations); must be >= 1
- TIMEOUT, 8, DRAIN cycles allowed before abort (used only with HILO_TIMEOUT_EN)

- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  multiply request; sampled only in IDLE
- OpA, OpB  in  32  operands, captured when Start is accepted
- MtHi, MtLo  in  1  write WrData into Hi / Lo
- WrData  in  32  MTHI/MTLO data
- MultA, MultB  out  32  registered operands to the multiplier; stable from RUN to CLEAR
- MultControl  out  1  multiplier enable
- MultClr  out  1  active-high multiplier clear, asserted for one cycle
- MultHi, MultLo  in  32  product halves from the multiplier
- MultOut  in  1  multiplier completion flag
- Hi, Lo  out  32  architectural HI/LO
- Busy  out  1  stall to the control unit
- Done  out  1  one-cycle completion pulse
- Error  out  1  one-cycle timeout pulse; constant 0 without HILO_TIMEOUT_EN

## Operation
- States:
  - IDLE -> RUN on Start.
  - RUN -> DRAIN after RUN_CYCLES cycles.
  - DRAIN -> CLEAR on MultOut==1, or on timeout.
  - CLEAR -> IDLE unconditionally.
- Reset (Reset==0), asynchronous, including mid-operation:
  - State returns to IDLE.
  - Hi, Lo, MultA, MultB and the counter are cleared to 0.
  - MultControl, MultClr, Busy, Done and Error are 0.
- IDLE:
  - Start==1 latches OpA/OpB into MultA/MultB and loads the counter with RUN_CYCLES.
  - MtHi / MtLo write WrData into Hi / Lo. Both may assert together, writing both.
  - A Mt write and Start in the same cycle are both honoured; the later product overwrites.
- RUN:
  - MultControl=1.
  - The counter decrements each cycle; leave RUN when the counter reaches 1.
- DRAIN:
  - MultControl=0.
  - On the edge where MultOut==1: Hi<=MultHi, Lo<=MultLo, Done<=1, go to CLEAR.
- CLEAR:
  - MultClr=1, decoded from state.
  - Done is high this cycle.
- Busy is 1 in every state except IDLE.
- Start, MtHi and MtLo are ignored while Busy==1.
- A MultOut already high on entry to DRAIN is accepted immediately.
- Products are signed 64-bit values passed through unmodified. No arithmetic is done in this block.

## Timing
- Cycle numbering with Start high in cycle 0 and a multiplier that raises MultOut one cycle after MultControl falls:
  - RUN is cycles 1–33 (MultControl=1).
  - DRAIN is cycles 34–35.
  - MultOut is sampled high at the end of cycle 35.
  - CLEAR is cycle 36: Done=1, MultClr=1, new Hi/Lo visible.
  - IDLE resumes in cycle 37.
- Busy is high in cycles 1–36. A new Start is accepted in cycle 37 at the earliest.
- Hi/Lo change only at the DRAIN->CLEAR edge or on an IDLE Mt write. They are never glitched mid-sequence.

## Configuration
- HILO_TIMEOUT_EN defined:
  - A DRAIN counter aborts after TIMEOUT cycles without MultOut.
  - On abort the block goes to CLEAR with Error=1 and Done=0, and Hi/Lo are unchanged.
- HILO_TIMEOUT_EN undefined:
  - DRAIN waits indefinitely.
  - Error is tied to 0 and no timeout logic is built.

## Structure
- Package hilo_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, CLEAR);
  - default constants HILO_RUN_CYCLES=33 and HILO_TIMEOUT=8;
  - a 6-bit counter width constant.
- Single module with no sub-module. The run counter and the timeout counter share one register, reloaded on the RUN->DRAIN transition.

## Test plan
- OpA=7, OpB=-3 with a behavioural 33-cycle multiplier model -> MultControl high for exactly 33 cycles, Done in cycle 36, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, single MultClr pulse.
- IDLE MtHi=1, MtLo=1, WrData=0xDEADBEEF -> Hi=Lo=0xDEADBEEF next cycle; Busy stays 0.
- Start again in cycles 5 and 20 of a run, plus MtLo=1 in cycle 10 -> all ignored; product and Lo reflect only the first request.
- Reset pulled low in cycle 12 of RUN -> outputs immediately 0 and state IDLE; a subsequent Start of 0x10000 × 0x10000 gives Hi=0x1, Lo=0x0.
- HILO_TIMEOUT_EN with MultOut held 0 -> Error pulse 8 cycles after DRAIN entry, Done=0, Hi/Lo unchanged, back to IDLE.
- Multiplier model raising MultOut 3 cycles late -> Done delayed by 3 cycles, with correct capture of 0x7FFFFFFF × 0x7FFFFFFF = Hi 0x3FFFFFFF, Lo 0x00000001.
